// File: rtl/qpb_pkg.sv
// qpb_pkg: width derivations and bank/row address split shared by query_patch_buffer and its banks.
package qpb_pkg;
    function automatic int patch_w(input int data_width, input int patch_size);
        return data_width * patch_size;
    endfunction
    function automatic int num_slices(input int pw, input int mw);
        return (pw + mw - 1) / mw;
    endfunction
    function automatic int addr_width(input int num_banks, input int bank_depth);
        return $clog2(num_banks * bank_depth);
    endfunction
    function automatic int bank_of(input int addr, input int bank_depth);
        return addr / bank_depth;
    endfunction
    function automatic int row_of(input int addr, input int bank_depth);
        return addr % bank_depth;
    endfunction
endpackage

// File: rtl/patch_sram_bank.sv
// patch_sram_bank: one bank row of column-sliced macros sharing a write and a read chip-select.
module patch_sram_bank
    import qpb_pkg::*;
#(
    parameter int PATCH_W = 55,
    parameter int MACRO_WIDTH = 32,
    parameter int ROW_W = 8,
    localparam int NS = num_slices(PATCH_W, MACRO_WIDTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ROW_W-1:0]   wr_row,
    input  logic [PATCH_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [ROW_W-1:0]   rd_row,
    output logic [PATCH_W-1:0] rd_data
);
    logic [NS*MACRO_WIDTH-1:0] wr_words;
    logic [NS*MACRO_WIDTH-1:0] rd_words;
    logic [MACRO_WIDTH-1:0]    port0_unused [NS];
    assign wr_words = (NS*MACRO_WIDTH)'(wr_data);
    assign rd_data  = rd_words[PATCH_W-1:0];
    for (genvar s = 0; s < NS; s++) begin : g_slice
        sky130_sram_1kbyte_1rw1r_32x256_8 u_macro (
            .clk0   (clk),
            .csb0   (!wr_en),
            .web0   (1'b0),
            .wmask0 (4'hF),
            .addr0  (wr_row),
            .din0   (wr_words[s*MACRO_WIDTH +: MACRO_WIDTH]),
            .dout0  (port0_unused[s]),
            .clk1   (clk),
            .csb1   (!rd_en),
            .addr1  (rd_row),
            .dout1  (rd_words[s*MACRO_WIDTH +: MACRO_WIDTH])
        );
    end
    // padding bits of the last slice are read back but discarded
    if (NS*MACRO_WIDTH > PATCH_W) begin : g_pad
        logic pad_unused;
        assign pad_unused = ^rd_words[NS*MACRO_WIDTH-1:PATCH_W];
    end
endmodule

// File: rtl/sky130_sram_1kbyte_1rw1r_32x256_8.sv
// sky130_sram_1kbyte_1rw1r_32x256_8: behavioural model of the 32x256 1rw1r macro.
// Selects are active-low; both ports capture on their clock and return read data after it.
module sky130_sram_1kbyte_1rw1r_32x256_8 (
    input  logic        clk0,
    input  logic        csb0,
    input  logic        web0,
    input  logic [3:0]  wmask0,
    input  logic [7:0]  addr0,
    input  logic [31:0] din0,
    output logic [31:0] dout0,
    input  logic        clk1,
    input  logic        csb1,
    input  logic [7:0]  addr1,
    output logic [31:0] dout1
);
    logic [31:0] mem [256];
    always_ff @(posedge clk0) begin
        if (!csb0 && !web0)
            for (int i = 0; i < 4; i++)
                if (wmask0[i]) mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
        if (!csb0 && web0) dout0 <= mem[addr0];
    end
    always_ff @(posedge clk1)
        if (!csb1) dout1 <= mem[addr1];
endmodule

// File: rtl/query_patch_buffer.sv
// query_patch_buffer: banked patch store, filled in arrival order, read back by address with 1-cycle latency.
module query_patch_buffer
    import qpb_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int MACRO_WIDTH = 32,
    parameter int BANK_DEPTH = 256,
    parameter int NUM_BANKS = 2,
    localparam int PATCH_W = patch_w(DATA_WIDTH, PATCH_SIZE),
    localparam int ADDR_WIDTH = addr_width(NUM_BANKS, BANK_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [PATCH_W-1:0]    wr_patch,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  full,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [PATCH_W-1:0]    rd_patch,
    output logic                  rd_oob
);
    localparam int DEPTH = NUM_BANKS * BANK_DEPTH;
    localparam int ROW_W = $clog2(BANK_DEPTH);
    localparam int BANK_W = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
    logic                  fire;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [BANK_W-1:0]     rd_bank;
    logic [PATCH_W-1:0]    bank_rd [NUM_BANKS];
    assign full     = wr_count == (ADDR_WIDTH+1)'(DEPTH);
    assign wr_ready = !rst && !full && !clear;
    assign fire     = wr_valid && wr_ready;
    assign wr_addr  = wr_count[ADDR_WIDTH-1:0];
    assign rd_patch = rd_valid ? bank_rd[rd_bank] : '0;
    // bank select and oob travel with the request so the output mux matches the macro data
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_count <= '0;
            rd_valid <= 1'b0;
            rd_oob   <= 1'b0;
            rd_bank  <= '0;
        end else begin
            wr_count <= clear ? '0 : wr_count + (ADDR_WIDTH+1)'(fire);
            rd_valid <= rd_req;
            rd_oob   <= rd_req && ({1'b0, rd_addr} >= wr_count);
            if (rd_req) rd_bank <= BANK_W'(bank_of(int'(rd_addr), BANK_DEPTH));
        end
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        patch_sram_bank #(
            .PATCH_W     (PATCH_W),
            .MACRO_WIDTH (MACRO_WIDTH),
            .ROW_W       (ROW_W)
        ) u_bank (
            .clk     (clk),
            .wr_en   (fire && bank_of(int'(wr_addr), BANK_DEPTH) == b),
            .wr_row  (ROW_W'(row_of(int'(wr_addr), BANK_DEPTH))),
            .wr_data (wr_patch),
            .rd_en   (rd_req && bank_of(int'(rd_addr), BANK_DEPTH) == b),
            .rd_row  (ROW_W'(row_of(int'(rd_addr), BANK_DEPTH))),
            .rd_data (bank_rd[b])
        );
    end
endmodule

// File: tb/tb_query_patch_buffer.sv
// tb_query_patch_buffer: scoreboard bench for query_patch_buffer with a reference fill model.
module tb_query_patch_buffer;
    localparam int PW = 55;
    localparam int AW = 9;
    localparam int DEPTH = 512;
    localparam int RA [8] = '{0, 255, 256, 511, 1, 300, 2, 301};
    typedef struct { logic oob; logic [PW-1:0] data; } exp_t;

    logic clk = 0, rst = 1, clear = 0, wr_valid = 0, rd_req = 0;
    logic [PW-1:0] wr_patch = '0;
    logic [AW-1:0] rd_addr = '0;
    logic wr_ready, full, rd_valid, rd_oob;
    logic [AW:0] wr_count;
    logic [PW-1:0] rd_patch;
    int total = 0, bad = 0, mdl_count = 0;
    logic [PW-1:0] mdl_mem [DEPTH];
    exp_t sb [$];
    exp_t e;

    always #5 clk = ~clk;

    query_patch_buffer dut (
        .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_patch(wr_patch), .wr_count(wr_count), .full(full), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_patch(rd_patch), .rd_oob(rd_oob)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] pat(input int i, input bit inv);
        logic [62:0] r;
        r = {7{9'(i)}};
        return inv ? ~r[PW-1:0] : r[PW-1:0];
    endfunction

    // one clock: check flow-control outputs, queue read expectations, then advance the fill model
    task automatic tick();
        bit acc;
        #1;
        acc = wr_valid && !clear && mdl_count < DEPTH;
        check("wr_ready", wr_ready, !clear && mdl_count < DEPTH);
        check("wr_count", wr_count, mdl_count);
        check("full", full, mdl_count == DEPTH);
        if (rd_req) sb.push_back('{int'(rd_addr) >= mdl_count, mdl_mem[rd_addr]});
        @(posedge clk);
        #1;
        if (clear) mdl_count = 0;
        else if (acc) begin
            mdl_mem[mdl_count] = wr_patch;
            mdl_count++;
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid && sb.size() == 0) check("rd_spurious", rd_valid, 0);
        else if (rd_valid) begin
            e = sb.pop_front();
            check("rd_oob", rd_oob, e.oob);
            if (!e.oob) check("rd_data", rd_patch, e.data);
        end else check("rd_idle", rd_patch, 0);
    end

    initial begin
        #2;
        check("rst_ready", wr_ready, 0);
        check("rst_count", wr_count, 0);
        check("rst_full", full, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_oob", rd_oob, 0);
        check("rst_patch", rd_patch, 0);
        @(posedge clk);
        #1;
        rst = 0;
        wr_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_patch = pat(i, 0);
            tick();
        end
        wr_patch = pat(513, 1);
        for (int i = 0; i < 8; i++) begin
            rd_req = 1;
            rd_addr = AW'(RA[i]);
            tick();
        end
        rd_req = 0;
        tick();
        tick();
        check("sb_drain_fill", sb.size(), 0);
        wr_valid = 0;
        clear = 1;
        tick();
        clear = 0;
        wr_valid = 1;
        for (int i = 0; i < 10; i++) begin
            wr_patch = pat(i, 1);
            tick();
        end
        wr_patch = pat(10, 1);
        rd_req = 1;
        rd_addr = 10;
        tick();
        wr_valid = 0;
        rd_addr = 50;
        tick();
        rd_addr = 9;
        tick();
        rd_addr = 300;
        tick();
        rd_addr = 10;
        tick();
        rd_req = 0;
        wr_valid = 1;
        for (int i = 11; i < 20; i++) begin
            wr_patch = pat(i, 1);
            tick();
        end
        clear = 1;
        wr_patch = pat(77, 0);
        tick();
        clear = 0;
        wr_valid = 0;
        tick();
        rd_req = 1;
        rd_addr = 3;
        tick();
        rd_req = 0;
        check("mid_valid_pre", rd_valid, 1);
        rst = 1;
        #1;
        check("rst_mid_valid", rd_valid, 0);
        check("rst_mid_patch", rd_patch, 0);
        check("rst_mid_ready", wr_ready, 0);
        check("rst_mid_count", wr_count, 0);
        sb.delete();
        mdl_count = 0;
        @(posedge clk);
        #1;
        rst = 0;
        tick();
        tick();
        check("sb_drain_end", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/query_patch_buffer.md
Name: query_patch_buffer

Overview:
Parametrised, banked store for query-image patches streamed in over I/O. Patches are written in arrival order using an internal write-address counter. The compute datapath reads them back by random address over an independent port. It replaces fixed two-macro hand wiring with generated banks and column slices of 1rw1r SRAM macros. It adds flow control, fill tracking and a correctly registered read-bank mux.

Parameters:
DATA_WIDTH, 11, bits per patch element
PATCH_SIZE, 5, elements per patch
MACRO_WIDTH, 32, data width of one SRAM macro
BANK_DEPTH, 256, words per macro
NUM_BANKS, 2, macro rows; DEPTH = NUM_BANKS*BANK_DEPTH (default 512)
PATCH_W (derived), DATA_WIDTH*PATCH_SIZE (55)
NUM_SLICES (derived), ceil(PATCH_W/MACRO_WIDTH) (2)
ADDR_WIDTH (derived), clog2(DEPTH) (9)

Ports:
clk  in  1  clock
rst  in  1  reset
clear  in  1  synchronous restart of fill; contents not erased
wr_valid  in  1  write patch offered
wr_ready  out  1  buffer accepts patch
wr_patch  in  PATCH_W  patch data, element 0 in LSBs
wr_count  out  ADDR_WIDTH+1  patches stored (0..DEPTH)
full  out  1  wr_count == DEPTH
rd_req  in  1  read request
rd_addr  in  ADDR_WIDTH  patch index
rd_valid  out  1  rd_patch valid this cycle
rd_patch  out  PATCH_W  read data
rd_oob  out  1  qualifies rd_valid: the address was >= wr_count when requested

Behaviour:
- Single clock domain, clk. Reset rst is asynchronous, active-high.
- Reset values: wr_count=0, full=0, wr_ready=0 while rst is high, rd_valid=0, rd_oob=0, rd_patch=0.
- wr_ready = !full && !clear.
- Write handshake: a write fires when wr_valid && wr_ready. The patch goes to address wr_count, and wr_count increments the next cycle. No write occurs without a handshake.
- Bank mapping: bank = addr / BANK_DEPTH, row = addr % BANK_DEPTH. Only the selected bank's macros get the write/read chip-select; all others stay deselected.
- Slice mapping: slice s holds bits [s*MACRO_WIDTH +: MACRO_WIDTH]. The last slice is zero-padded on write and truncated on read. Wmask is all ones.
- full: rises in the cycle after the DEPTH-th accepted write. Further wr_valid is stalled, never dropped or wrapped. wr_count saturates at DEPTH.
- clear: next cycle wr_count=0 and full=0. A write offered in the clear cycle is not accepted. rst and clear do not erase macro contents.
- Read latency is exactly 1. rd_req in cycle N gives rd_valid=1 in N+1, with rd_patch from the bank selected by rd_addr in cycle N. The bank select and the oob flag are registered alongside the request.
- Back-to-back reads: one per cycle, full throughput.
- rd_oob=1 when rd_addr >= wr_count in the request cycle. rd_patch content is then undefined but is still delivered.
- Reads of addresses already written (address < wr_count at request time) return the stored data regardless of concurrent writes elsewhere.
- Same-address read/write in one cycle: the address equals wr_count, so rd_oob=1 and the data is undefined.
- rd_patch is forced to 0 whenever rd_valid=0.
- clear during an in-flight read: the read still completes with its registered oob flag.
- rst asserted mid-operation: all outputs return to reset values immediately. A pending rd_valid is cancelled.

Decomposition:
- Package qpb_pkg holds: the derived-width functions (PATCH_W, NUM_SLICES, ADDR_WIDTH computation) and the bank/row split helper.
- Sub-module patch_sram_bank covers one bank row. It holds NUM_SLICES macros of sky130_sram_1kbyte_1rw1r_32x256_8, with write data padding/splitting, read concatenation and a common chip-select.
- The top level contains the write counter/flow control, bank decode, read pipeline register and the output mux.

Test Plan:
- Reset then idle: wr_ready=1 after rst falls, wr_count=0, rd_valid=0, rd_patch=0.
- Write patches 0x0..0x1FF (value = index replicated) with wr_valid constant. Read addresses 0,255,256,511. Expected: rd_valid one cycle later with matching data, rd_oob=0; bank crossing at 255/256 correct.
- Write 512 patches then hold wr_valid high. Expected: full=1 and wr_ready=0 from the following cycle, wr_count=512; the 513th patch is never written (address 0 still reads its original value).
- Streaming reads with alternating banks (1, 300, 2, 301) every cycle. Expected: each response matches its request with 1-cycle latency, with no bank-mux cross-talk.
- After 10 writes, read address 10 while address 10 is being written, and read address 50. Expected: rd_oob=1 on both; a read of address 9 gives rd_oob=0 with correct data.
- clear asserted together with wr_valid after 20 writes. Expected: the write is not accepted and wr_count=0 next cycle. Then set rst mid-read: rd_valid drops to 0 immediately.
